// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - command/address/data register-access controller behind a byte-level SPI slave
//
// Decodes SPI messages of the form: command byte {rw, addr[6:0]} followed by
// data bytes. Writes land in a bank of 2**AW 8-bit registers, and reads stream
// them back one byte late through tx_byte. The address pointer auto-increments
// and wraps modulo the bank size.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   msg_start       1-cycle pulse, chip select asserted
//   msg_end         1-cycle pulse, chip select released
//   rx_valid        1-cycle pulse, rx_byte holds a received byte
//   rx_byte[7:0]    received byte
//   tx_byte[7:0]    byte the slave shifts out at its next byte boundary
//   busy            message in progress
//   wr_strobe       1-cycle pulse per register write, with wr_addr / wr_data
//   regs_flat       register bank, reg[i] = regs_flat[8*i+7:8*i]

module spi_reg_ctrl #(
    parameter int          AW        = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [7:0]  ERR_BYTE  = 8'hEE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    msg_start,
    input  logic                    msg_end,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    output logic [7:0]              tx_byte,
    output logic                    busy,
    output logic                    wr_strobe,
    output logic [AW-1:0]           wr_addr,
    output logic [7:0]              wr_data,
    output logic [8*(2**AW)-1:0]    regs_flat
);

    localparam int NREGS = 2 ** AW;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        ERR
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   addr, addr_n;
    logic [7:0]      tx_n;
    logic            we_n;
    logic [AW-1:0]   wa_n;
    logic [7:0]      wd_n;
    logic [7:0]      regs [NREGS];

    logic [AW-1:0]   cmd_addr;
    logic            cmd_oor;

    assign cmd_addr = rx_byte[AW-1:0];
    // Any set address bit above the bank width makes the command invalid.
    // Shifting by AW leaves zero when AW == 7, so no bits are out of range then.
    assign cmd_oor  = ((rx_byte[6:0] >> AW) != 7'd0);

    always_comb begin
        state_n = state;
        addr_n  = addr;
        tx_n    = tx_byte;
        we_n    = 1'b0;
        wa_n    = wr_addr;
        wd_n    = wr_data;

        if (msg_start) begin
            // A new message always wins; a byte arriving in the same cycle
            // belongs to no command and is dropped.
            state_n = CMD;
            tx_n    = SYNC_BYTE;
        end else begin
            if (rx_valid) begin
                unique case (state)
                    CMD: begin
                        if (cmd_oor) begin
                            state_n = ERR;
                            tx_n    = ERR_BYTE;
                        end else if (rx_byte[7]) begin
                            state_n = WRITE;
                            addr_n  = cmd_addr;
                            tx_n    = 8'h00;
                        end else begin
                            state_n = READ;
                            addr_n  = cmd_addr + AW'(1);
                            tx_n    = regs[cmd_addr];
                        end
                    end
                    WRITE: begin
                        we_n   = 1'b1;
                        wa_n   = addr;
                        wd_n   = rx_byte;
                        addr_n = addr + AW'(1);
                        tx_n   = 8'h00;
                    end
                    READ: begin
                        tx_n   = regs[addr];
                        addr_n = addr + AW'(1);
                    end
                    default: begin
                        // IDLE and ERR: byte is ignored, tx_byte holds.
                    end
                endcase
            end
            // Closing the message after the byte above lets a final write commit.
            if (msg_end) begin
                state_n = IDLE;
                tx_n    = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            tx_byte   <= 8'h00;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            tx_byte   <= tx_n;
            wr_strobe <= we_n;
            wr_addr   <= wa_n;
            wr_data   <= wd_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we_n) begin
            regs[addr] <= rx_byte;
        end
    end

    assign busy = (state != IDLE);

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - self-checking bench for spi_reg_ctrl against a message-level model
`timescale 1ns/1ps

module tb_spi_reg_ctrl;

    localparam int AW    = 4;
    localparam int NREGS = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  msg_start = 1'b0;
    logic                  msg_end = 1'b0;
    logic                  rx_valid = 1'b0;
    logic [7:0]            rx_byte = 8'h00;
    logic [7:0]            tx_byte;
    logic                  busy;
    logic                  wr_strobe;
    logic [AW-1:0]         wr_addr;
    logic [7:0]            wr_data;
    logic [8*NREGS-1:0]    regs_flat;

    spi_reg_ctrl #(.AW(AW), .SYNC_BYTE(8'hA5), .ERR_BYTE(8'hEE)) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_start (msg_start),
        .msg_end   (msg_end),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .regs_flat (regs_flat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_strobes = 0;
    bit chk_en = 1'b0;

    // Message-level model: what kind of message we are in, where the pointer is,
    // and what the bank holds.
    localparam int M_IDLE = 0, M_CMD = 1, M_WR = 2, M_RD = 3, M_ERR = 4;
    int         m_mode = M_IDLE;
    int         m_ptr  = 0;
    logic [7:0] m_regs [NREGS];
    logic [7:0] e_tx = 8'h00;
    bit         e_strobe = 1'b0;
    int         e_wa = 0;
    logic [7:0] e_wd = 8'h00;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8*NREGS-1:0] model_flat();
        logic [8*NREGS-1:0] f;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    // Apply the effect of one clock edge with the given inputs to the model.
    task automatic model_step(input bit r, input bit ms, input bit me, input bit rv, input logic [7:0] rb);
        int a;
        if (r) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
            m_mode = M_IDLE; m_ptr = 0; e_tx = 8'h00;
            e_strobe = 1'b0; e_wa = 0; e_wd = 8'h00;
            return;
        end
        e_strobe = 1'b0;
        if (ms) begin
            m_mode = M_CMD;
            e_tx = 8'hA5;
            return;
        end
        if (rv) begin
            a = int'(rb[6:0]);
            case (m_mode)
                M_CMD: begin
                    if (a >= NREGS) begin
                        m_mode = M_ERR; e_tx = 8'hEE;
                    end else if (rb[7]) begin
                        m_mode = M_WR; m_ptr = a; e_tx = 8'h00;
                    end else begin
                        m_mode = M_RD; e_tx = m_regs[a]; m_ptr = (a + 1) % NREGS;
                    end
                end
                M_WR: begin
                    m_regs[m_ptr] = rb;
                    e_strobe = 1'b1; e_wa = m_ptr; e_wd = rb;
                    m_ptr = (m_ptr + 1) % NREGS;
                    e_tx = 8'h00;
                end
                M_RD: begin
                    e_tx = m_regs[m_ptr];
                    m_ptr = (m_ptr + 1) % NREGS;
                end
                default: ;
            endcase
        end
        if (me) begin
            m_mode = M_IDLE;
            e_tx = 8'h00;
        end
    endtask

    // One clock of stimulus; inputs change 1 ns after the edge, away from sampling.
    task automatic cyc(input bit r, input bit ms, input bit me, input bit rv, input logic [7:0] rb);
        #1;
        rst = r; msg_start = ms; msg_end = me; rx_valid = rv;
        rx_byte = rv ? rb : 8'($urandom_range(0, 255));
        @(posedge clk);
        model_step(r, ms, me, rv, rb);
        #1;
        rst = 1'b0; msg_start = 1'b0; msg_end = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00);
    endtask

    task automatic rxb(input logic [7:0] b);
        cyc(0, 0, 0, 1, b);
    endtask

    task automatic send_msg(input logic [7:0] bytes [$]);
        cyc(0, 1, 0, 0, 8'h00);
        foreach (bytes[i]) begin
            idle($urandom_range(1, 3));
            rxb(bytes[i]);
        end
        idle(2);
        cyc(0, 0, 1, 0, 8'h00);
        idle(1);
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        return regs_flat[8*i +: 8];
    endfunction

    // Per-cycle comparison of every observable output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_byte", 128'(tx_byte), 128'(e_tx));
            chk("busy", 128'(busy), 128'(m_mode != M_IDLE));
            chk("wr_strobe", 128'(wr_strobe), 128'(e_strobe));
            if (e_strobe) begin
                chk("wr_addr", 128'(wr_addr), 128'(e_wa));
                chk("wr_data", 128'(wr_data), 128'(e_wd));
            end
            chk("regs_flat", 128'(regs_flat), 128'(model_flat()));
            if (wr_strobe) n_strobes++;
        end
    end

    initial begin
        logic [7:0] q [$];
        int s0;
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;

        cyc(1, 0, 0, 0, 8'h00);
        chk_en = 1'b1;
        cyc(1, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("reset_regs", 128'(regs_flat), 128'h0);
        chk("reset_tx", 128'(tx_byte), 128'h00);
        chk("reset_busy", 128'(busy), 128'h0);

        // Write burst starting at register 2.
        s0 = n_strobes;
        q = '{8'h82, 8'h11, 8'h22, 8'h33};
        send_msg(q);
        @(negedge clk);
        chk("wb_reg2", 128'(dut_reg(2)), 128'h11);
        chk("wb_reg3", 128'(dut_reg(3)), 128'h22);
        chk("wb_reg4", 128'(dut_reg(4)), 128'h33);
        chk("wb_strobes", 128'(n_strobes - s0), 128'd3);
        chk("wb_busy", 128'(busy), 128'h0);

        // Read burst with one-byte lag.
        q = '{8'h85, 8'h5A, 8'h6B};
        send_msg(q);
        cyc(0, 1, 0, 0, 8'h00);
        @(negedge clk); chk("rd_sync", 128'(tx_byte), 128'hA5);
        rxb(8'h05);
        @(negedge clk); chk("rd_first", 128'(tx_byte), 128'h5A);
        idle(2);
        rxb(8'h00);
        @(negedge clk); chk("rd_second", 128'(tx_byte), 128'h6B);
        rxb(8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        idle(1);

        // Address wrap, write then read.
        q = '{8'h8F, 8'hAA, 8'hBB};
        send_msg(q);
        @(negedge clk);
        chk("wrap_reg15", 128'(dut_reg(15)), 128'hAA);
        chk("wrap_reg0", 128'(dut_reg(0)), 128'hBB);
        cyc(0, 1, 0, 0, 8'h00);
        rxb(8'h0F);
        @(negedge clk); chk("wrap_rd15", 128'(tx_byte), 128'hAA);
        idle(1);
        rxb(8'h00);
        @(negedge clk); chk("wrap_rd0", 128'(tx_byte), 128'hBB);
        cyc(0, 0, 1, 0, 8'h00);

        // Out-of-range command.
        s0 = n_strobes;
        cyc(0, 1, 0, 0, 8'h00);
        rxb(8'h90);
        idle(1);
        rxb(8'h77);
        @(negedge clk);
        chk("oor_tx", 128'(tx_byte), 128'hEE);
        chk("oor_nostrobe", 128'(n_strobes - s0), 128'd0);
        cyc(0, 0, 1, 0, 8'h00);

        // msg_end coincident with write data.
        cyc(0, 1, 0, 0, 8'h00);
        rxb(8'h83);
        idle(1);
        cyc(0, 0, 1, 1, 8'h99);
        @(negedge clk);
        chk("end_wr_reg3", 128'(dut_reg(3)), 128'h99);
        chk("end_wr_strobe", 128'(wr_strobe), 128'h1);
        chk("end_wr_busy", 128'(busy), 128'h0);

        // msg_start coincident with rx_valid: byte dropped.
        cyc(0, 1, 0, 1, 8'h85);
        @(negedge clk);
        chk("start_rv_tx", 128'(tx_byte), 128'hA5);
        chk("start_rv_busy", 128'(busy), 128'h1);
        cyc(0, 0, 1, 0, 8'h00);

        // Reset mid-write, then a stray byte.
        cyc(0, 1, 0, 0, 8'h00);
        rxb(8'h81);
        idle(1);
        rxb(8'h44);
        cyc(1, 0, 0, 0, 8'h00);
        rxb(8'h55);
        @(negedge clk);
        chk("rst_regs", 128'(regs_flat), 128'h0);
        chk("rst_tx", 128'(tx_byte), 128'h00);
        chk("rst_strobe", 128'(wr_strobe), 128'h0);

        // Randomized messages.
        for (int m = 0; m < 60; m++) begin
            int nb;
            logic [7:0] b;
            cyc(0, 1, 0, 0, 8'h00);
            nb = $urandom_range(0, 6);
            for (int k = 0; k < nb; k++) begin
                idle($urandom_range(0, 2));
                if (k == 0) begin
                    b = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                                    : {1'($urandom_range(0, 1)), 3'b000, 4'($urandom_range(0, 15))};
                end else begin
                    b = 8'($urandom_range(0, 255));
                end
                if (k == nb - 1 && $urandom_range(0, 1) == 1) begin
                    cyc(0, 0, 1, 1, b);
                end else begin
                    cyc(0, 0, 0, 1, b);
                    if (k == nb - 1) cyc(0, 0, 1, 0, 8'h00);
                end
                if ($urandom_range(0, 40) == 0) cyc(1, 0, 0, 0, 8'h00);
            end
            if (nb == 0) cyc(0, 0, 1, 0, 8'h00);
            if ($urandom_range(0, 3) == 0) rxb(8'($urandom_range(0, 255)));
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
